// File: rtl/imem_boot_loader_pkg.sv
// Shared constants for the instruction-memory boot loader and the instruction memory itself.
package imem_boot_pkg;

    localparam int IMEM_ADDR_W    = 6;
    localparam int IMEM_DEPTH     = 64;
    localparam int BYTES_PER_WORD = 4;

    // Loader FSM encoding, kept as plain constants so older blocks can share it.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_boot_loader_if import imem_boot_pkg::*; #(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // Byte source / memory side.
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_word_packer.sv
// Assembles little-endian bytes into a 32-bit instruction word.
module imem_word_packer import imem_boot_pkg::*; (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_full
);

    logic [1:0]  idx;
    logic [31:0] word;

    // The word as it would look with byte_in inserted at the current byte position.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        word_next = word;
        word_next[{idx, 3'b000} +: 8] = byte_in;
    end

    assign word_full = (idx == 2'(BYTES_PER_WORD - 1));

    // Byte index and partial word; cleared on reset or a new load so stale bytes never leak.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            idx  <= '0;
            word <= '0;
        end else if (clr) begin
            idx  <= '0;
            word <= '0;
        end else if (push) begin
            idx  <= idx + 2'd1;
            word <= word_next;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams bytes into instruction memory and holds the core until the load completes.
module imem_boot_loader import imem_boot_pkg::*; #(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    imem_boot_loader_if.slave bus,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    logic [1:0]        state;
    logic [1:0]        state_n;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   word_idx;
    logic [ADDR_W:0]   word_idx_inc;
    logic              start_ok;
    logic              too_big;
    logic              byte_take;
    logic              word_full;
    logic [31:0]       word_next;

    assign start_ok     = start && (state == ST_IDLE || state == ST_DONE);
    assign too_big      = (word_count > DEPTH_C);
    assign byte_take    = bus.in_valid && bus.in_ready;
    assign word_idx_inc = word_idx + (ADDR_W + 1)'(1);

    imem_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start_ok && !too_big),
        .push      (byte_take),
        .byte_in   (bus.in_data),
        .word_next (word_next),
        .word_full (word_full)
    );

    // Next-state decision for the load sequence.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (too_big)                state_n = ST_IDLE;
                    else if (word_count == '0)  state_n = ST_DONE;
                    else                        state_n = ST_LOAD;
                end
            end
            ST_LOAD:  if (byte_take && word_full) state_n = ST_WRITE;
            ST_WRITE: state_n = (word_idx_inc == count_q) ? ST_DONE : ST_LOAD;
            default:  state_n = ST_IDLE;
        endcase
    end

    // State, counters and every output register; outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            count_q       <= '0;
            word_idx      <= '0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            cpu_run       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state        <= state_n;
            bus.in_ready <= (state_n == ST_LOAD);
            bus.mem_we   <= (state_n == ST_WRITE);
            busy         <= (state_n == ST_LOAD) || (state_n == ST_WRITE);
            cpu_run      <= (state_n == ST_DONE);
            done         <= (state_n == ST_DONE);

            if (start_ok) begin
                if (too_big) begin
                    err <= 1'b1;
                end else begin
                    err      <= 1'b0;
                    count_q  <= word_count;
                    word_idx <= '0;
                end
            end

            if (state == ST_WRITE) word_idx <= word_idx_inc;

            // Address/data only move when a write is launched, so they hold otherwise.
            if (state_n == ST_WRITE) begin
                bus.mem_addr  <= word_idx[ADDR_W-1:0];
                bus.mem_wdata <= DATA_W'(word_next);
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized scoreboard bench for imem_boot_loader.
module tb_imem_boot_loader;
    import imem_boot_pkg::*;

    typedef struct packed {
        logic [IMEM_ADDR_W-1:0] addr;
        logic [31:0]            data;
    } wr_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [IMEM_ADDR_W:0] word_count = '0;
    logic                 cpu_run, busy, done, err;

    imem_boot_loader_if #(.ADDR_W(IMEM_ADDR_W), .DATA_W(32)) bus ();

    imem_boot_loader #(.ADDR_W(IMEM_ADDR_W), .DEPTH(IMEM_DEPTH), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .bus        (bus),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          errors   = 0;
    int          we_count = 0;
    int          gap_mode = 0;   // 0 = always valid, 1 = toggle, 2 = random gaps
    bit          tog      = 1'b0;
    wr_t         exp_q[$];
    logic [31:0] prog[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write the DUT presents must be the next one the model predicted.
    always @(negedge clk) begin
        check("run_busy_exclusive", 32'(cpu_run & busy), 32'd0);
        if (bus.mem_we === 1'b1) begin
            we_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", 32'(bus.mem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(bus.mem_addr), 32'(e.addr));
                check("write_data", bus.mem_wdata, e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int budget = 300;
        forever begin
            @(negedge clk);
            if ((gap_mode == 1 && !tog) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
                tog = ~tog;
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
            end else begin
                tog = ~tog;
                bus.in_valid = 1'b1;
                bus.in_data  = b;
                if (bus.in_ready) begin
                    @(posedge clk);
                    return;
                end
            end
            budget--;
            if (budget == 0) begin
                check("byte_accept_timeout", 32'd0, 32'd1);
                return;
            end
        end
    endtask

    task automatic do_start(input logic [IMEM_ADDR_W:0] cnt);
        @(negedge clk);
        start      = 1'b1;
        word_count = cnt;
        @(negedge clk);
        start      = 1'b0;
        word_count = 7'($urandom);   // the latched count must not follow the pin
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_cpu_run"}, 32'(cpu_run), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Reference: word i of the program lands at address i, bytes sent least significant first.
    task automatic run_load(input string tag);
        int we0;
        we0 = we_count;
        do_start(7'(prog.size()));
        foreach (prog[i]) exp_q.push_back({6'(i), prog[i]});
        foreach (prog[i])
            for (int b = 0; b < 4; b++) send_byte(prog[i][8*b +: 8]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_done(tag);
        check({tag, "_write_count"}, 32'(we_count - we0), 32'(prog.size()));
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_hold_addr"}, 32'(bus.mem_addr), 32'(prog.size() - 1));
        check({tag, "_hold_data"}, bus.mem_wdata, prog[prog.size() - 1]);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_cpu_run", 32'(cpu_run), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // 1: two-word program
        gap_mode = 0;
        prog = '{32'h0000_0013, 32'h0010_0093};
        run_load("t1");

        // 2: in_valid toggling every cycle
        gap_mode = 1;
        prog = '{32'hDDCC_BBAA};
        run_load("t2");
        gap_mode = 0;

        // 3: oversize count rejected, stray bytes ignored, then zero-length load
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        do_start(7'd65);
        check("t3_err", 32'(err), 32'd1);
        check("t3_in_ready", 32'(bus.in_ready), 32'd0);
        check("t3_cpu_run", 32'(cpu_run), 32'd0);
        check("t3_done", 32'(done), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("t3_err_sticky", 32'(err), 32'd1);
        check("t3_still_idle", 32'(bus.in_ready), 32'd0);
        do_start(7'd0);
        bus.in_valid = 1'b0;
        check("t3_zero_err", 32'(err), 32'd0);
        check("t3_zero_done", 32'(done), 32'd1);
        check("t3_zero_cpu_run", 32'(cpu_run), 32'd1);

        // 4: full-depth load of random words with random gaps
        gap_mode = 2;
        prog.delete();
        for (int i = 0; i < IMEM_DEPTH; i++) prog.push_back($urandom);
        run_load("t4");
        gap_mode = 0;

        // 5: reset in the middle of word 1 of a three-word load
        prog = '{32'hCAFE_F00D, 32'h1122_3344, 32'h5566_7788};
        do_start(7'd3);
        exp_q.push_back({6'd0, prog[0]});
        for (int b = 0; b < 4; b++) send_byte(prog[0][8*b +: 8]);
        send_byte(prog[1][7:0]);
        send_byte(prog[1][15:8]);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t5_in_ready", 32'(bus.in_ready), 32'd0);
        check("t5_mem_we", 32'(bus.mem_we), 32'd0);
        check("t5_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("t5_mem_wdata", bus.mem_wdata, 32'd0);
        check("t5_cpu_run", 32'(cpu_run), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_err", 32'(err), 32'd0);
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        rst_n = 1'b1;
        prog = '{32'($urandom)};
        run_load("t5r");

        // 6: restart from DONE drops cpu_run at once
        prog = '{32'h1234_5678};
        exp_q.push_back({6'd0, prog[0]});
        do_start(7'd1);
        check("t6_cpu_run_drop", 32'(cpu_run), 32'd0);
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_done_drop", 32'(done), 32'd0);
        for (int b = 0; b < 4; b++) send_byte(prog[0][8*b +: 8]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_done("t6");
        check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
        check("t6_hold_data", bus.mem_wdata, 32'h1234_5678);

        repeat (4) @(negedge clk);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
